// File: rtl/pc_unit_pkg.sv
// Shared command encoding and default parameters for the DLX program-counter unit.
package pc_unit_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD = 3'b000,
    CMD_LOAD = 3'b001,
    CMD_INC  = 3'b010,
    CMD_TRAP = 3'b011,
    CMD_RFE  = 3'b100
  } pc_cmd_t;

  localparam int unsigned DEFAULT_STEP     = 4;
  localparam int unsigned DEFAULT_TRAP_VEC = 0;

endpackage

// File: rtl/iar_stack.sv
// LIFO of saved interrupt return addresses; entries are indexed by the occupancy count.
module iar_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned DW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DW-1:0]    depth_reg;

  assign depth = depth_reg;
  assign full  = (depth_reg == DW'(DEPTH));
  assign empty = (depth_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_reg <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && !full && depth_reg == DW'(i)) mem_reg[i] <= din;
      end
      if (push && !full)
        depth_reg <= depth_reg + 1'b1;
      else if (pop && !empty)
        depth_reg <= depth_reg - 1'b1;
    end
  end

  // Empty stack reads as zero rather than a stale entry.
  always_comb begin
    top = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (depth_reg == DW'(i + 1)) top = mem_reg[i];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with LOAD/INC/TRAP/RFE commands, IAR stack and tristate bus drivers.
// Optional PC_ALIGN_CHECK_EN forces word alignment on LOAD/RFE and adds align_err.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     STEP     = DEFAULT_STEP,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEFAULT_TRAP_VEC),
  localparam int unsigned    DW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       pc_cmd,
  input  logic [WIDTH-1:0] addr_bus,
  input  logic             pc_oe_s1,
  input  logic             pc_oe_s2,
  input  logic             iar_oe_s1,
  output logic [WIDTH-1:0] s1_bus,
  output logic [WIDTH-1:0] s2_bus,
  output logic [WIDTH-1:0] pc_q,
  output logic [DW-1:0]    iar_depth,
  output logic             stk_err,
  output logic             bus_err
`ifdef PC_ALIGN_CHECK_EN
  , output logic           align_err
`endif
);

  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] load_src;
  logic [WIDTH-1:0] top;
  logic             load_en;
  logic             push, pop, full, empty;
  logic             stk_err_reg, stk_err_set;

  iar_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_iar_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_reg),
    .top   (top),
    .depth (iar_depth),
    .full  (full),
    .empty (empty)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic align_err_reg, align_set;
`endif

  always_comb begin
    pc_next     = pc_reg;
    load_src    = addr_bus;
    load_en     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    stk_err_set = 1'b0;
    case (pc_cmd)
      CMD_LOAD: load_en = 1'b1;
      CMD_INC:  pc_next = pc_reg + WIDTH'(STEP);
      CMD_TRAP: begin
        // Overflow still vectors to the handler; only the return address is lost.
        pc_next = TRAP_VEC;
        if (full) stk_err_set = 1'b1;
        else      push        = 1'b1;
      end
      CMD_RFE: begin
        if (empty) stk_err_set = 1'b1;
        else begin
          pop      = 1'b1;
          load_src = top;
          load_en  = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef PC_ALIGN_CHECK_EN
    align_set = 1'b0;
    if (load_en) begin
      pc_next   = {load_src[WIDTH-1:2], 2'b00};
      align_set = |load_src[1:0];
    end
`else
    if (load_en) pc_next = load_src;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg      <= '0;
      stk_err_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      stk_err_reg <= stk_err_reg | stk_err_set;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) align_err_reg <= 1'b0;
    else        align_err_reg <= align_err_reg | align_set;
  end
  assign align_err = align_err_reg;
`endif

  assign pc_q    = pc_reg;
  assign stk_err = stk_err_reg;
  assign bus_err = pc_oe_s1 & iar_oe_s1;

  // PC has priority on s1 when both sources are enabled.
  assign s1_bus = pc_oe_s1  ? pc_reg :
                  iar_oe_s1 ? top    : {WIDTH{1'bz}};
  assign s2_bus = pc_oe_s2  ? pc_reg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus random-command bench for pc_unit against a queue-based reference model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  pc_cmd = 3'd0;
  logic [31:0] addr_bus = '0;
  logic        pc_oe_s1 = 1'b0, pc_oe_s2 = 1'b0, iar_oe_s1 = 1'b0;
  logic [31:0] s1_bus, s2_bus, pc_q;
  logic [2:0]  iar_depth;
  logic        stk_err, bus_err;
`ifdef PC_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_stk_err;
  logic        m_align_err;

  localparam logic [31:0] TV = 32'h80;
  localparam logic [31:0] ZZ = 32'hzzzz_zzzz;

  pc_unit #(.WIDTH(32), .DEPTH(4), .STEP(4), .TRAP_VEC(TV)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_cmd    (pc_cmd),
    .addr_bus  (addr_bus),
    .pc_oe_s1  (pc_oe_s1),
    .pc_oe_s2  (pc_oe_s2),
    .iar_oe_s1 (iar_oe_s1),
    .s1_bus    (s1_bus),
    .s2_bus    (s2_bus),
    .pc_q      (pc_q),
    .iar_depth (iar_depth),
    .stk_err   (stk_err),
    .bus_err   (bus_err)
`ifdef PC_ALIGN_CHECK_EN
    , .align_err (align_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_fix(input logic [31:0] v);
`ifdef PC_ALIGN_CHECK_EN
    if (v[1:0] != 2'b00) m_align_err = 1'b1;
    return v & 32'hFFFF_FFFC;
`else
    return v;
`endif
  endfunction

  function automatic void model_reset();
    m_pc        = '0;
    m_stack     = {};
    m_stk_err   = 1'b0;
    m_align_err = 1'b0;
  endfunction

  function automatic void model_apply(input logic [2:0] c, input logic [31:0] a);
    case (c)
      3'd1: m_pc = word_fix(a);
      3'd2: m_pc = m_pc + 32'd4;
      3'd3: begin
        if (m_stack.size() < 4) m_stack.push_back(m_pc);
        else m_stk_err = 1'b1;
        m_pc = TV;
      end
      3'd4: begin
        if (m_stack.size() > 0) m_pc = word_fix(m_stack.pop_back());
        else m_stk_err = 1'b1;
      end
      default: ;
    endcase
  endfunction

  // Set the bus enables, let the combinational paths settle, compare everything.
  task automatic check_all(input string tag, input logic e1, input logic e2, input logic ie);
    logic [31:0] top, exp_s1, exp_s2;
    pc_oe_s1 = e1; pc_oe_s2 = e2; iar_oe_s1 = ie;
    #1;
    top    = (m_stack.size() > 0) ? m_stack[$] : 32'd0;
    exp_s1 = e1 ? m_pc : (ie ? top : ZZ);
    exp_s2 = e2 ? m_pc : ZZ;
    chk({tag, ".pc_q"},    pc_q, m_pc);
    chk({tag, ".depth"},   {29'd0, iar_depth}, 32'(m_stack.size()));
    chk({tag, ".stk_err"}, {31'd0, stk_err}, {31'd0, m_stk_err});
    chk({tag, ".s1_bus"},  s1_bus, exp_s1);
    chk({tag, ".s2_bus"},  s2_bus, exp_s2);
    chk({tag, ".bus_err"}, {31'd0, bus_err}, {31'd0, e1 & ie});
`ifdef PC_ALIGN_CHECK_EN
    chk({tag, ".align_err"}, {31'd0, align_err}, {31'd0, m_align_err});
`endif
    $display("[%0t] %s pc=%h depth=%0d stk_err=%b s1=%h s2=%h", $time, tag, pc_q, iar_depth, stk_err, s1_bus, s2_bus);
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic step(input logic [2:0] c, input logic [31:0] a);
    pc_cmd = c; addr_bus = a;
    @(posedge clk); #1;
    model_apply(c, a);
    pc_cmd = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all("reset", 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // INC x3 from reset
    for (int i = 0; i < 3; i++) step(3'd2, '0);
    chk("inc3.const", pc_q, 32'h0000_000C);
    check_all("inc3", 1'b0, 1'b0, 1'b0);

    // LOAD, TRAP, IAR on s1, RFE
    step(3'd1, 32'h0000_1000);
    step(3'd3, '0);
    chk("trap.const", pc_q, 32'h80);
    check_all("trap_iar", 1'b0, 1'b0, 1'b1);
    chk("trap.iar_s1", s1_bus, 32'h0000_1000);
    step(3'd4, '0);
    chk("rfe.const", pc_q, 32'h0000_1000);
    check_all("rfe", 1'b0, 1'b1, 1'b0);

    // Five nested traps with DEPTH=4, then unwind
    for (int i = 1; i <= 5; i++) begin
      step(3'd1, 32'h100 * i);
      step(3'd3, '0);
      check_all($sformatf("nest%0d", i), 1'b0, 1'b0, 1'b1);
    end
    chk("overflow.stk_err", {31'd0, stk_err}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(3'd4, '0);
      chk($sformatf("unwind%0d.const", k), pc_q, 32'h100 * (4 - k));
      check_all($sformatf("unwind%0d", k), 1'b1, 1'b0, 1'b1);
    end

    // Underflow is sticky until reset
    do_reset();
    step(3'd1, 32'h0000_0200);
    step(3'd4, '0);
    check_all("underflow", 1'b0, 1'b0, 1'b0);
    chk("underflow.stk_err", {31'd0, stk_err}, 32'd1);
    step(3'd2, '0);
    step(3'd0, '0);
    check_all("sticky", 1'b0, 1'b0, 1'b0);
    do_reset();

    // Wrap and bus contention
    step(3'd1, 32'hFFFF_FFFC);
    step(3'd2, '0);
    chk("wrap.const", pc_q, 32'd0);
    step(3'd3, '0);
    check_all("contend", 1'b1, 1'b0, 1'b1);

`ifdef PC_ALIGN_CHECK_EN
    step(3'd1, 32'h0000_0103);
    chk("align.const", pc_q, 32'h0000_0100);
    check_all("align", 1'b0, 1'b0, 1'b0);
`endif

    // Asynchronous reset in the middle of a pending TRAP
    step(3'd1, 32'h0000_0444);
    pc_cmd = 3'd3;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst", 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_all("rst_hold", 1'b0, 1'b0, 1'b1);
    pc_cmd = 3'd0;
    reset = 1'b1;

    // Random command stream
    for (int n = 0; n < 400; n++) begin
      logic [2:0]  c;
      logic [31:0] a;
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      if (n == 200) do_reset();
      step(c, a);
      check_all($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
